mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 243 ++++++++++++++++++++++++
 tb/tb_mem_stage.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage -- RV64I memory stage with a single outstanding data-memory access.
//
// Non-memory instructions (OP, OP-IMM, JAL, branches, anything unlisted) retire
// the cycle after they are accepted. LB/LW/SB/SW issue one word-aligned request
// and hold the pipeline (stall_o) until the memory answers or TIMEOUT cycles
// pass. Unsupported widths and misaligned word accesses retire as faults
// without touching memory.
//
// Ports:
//   clk_i, rsn_i          clock, asynchronous active-low reset
//   valid_i               execute stage presents an instruction
//   pc_i, instr_i         instruction PC and encoding
//   alu_result_i          ALU result / effective address
//   store_data_i          rs2 value for stores
//   mem_ready_i           memory accepts/completes the request this cycle
//   mem_rdata_i           aligned read word (valid with mem_ready_i on a read)
//   mem_req_o, mem_we_o   request strobe, 1 = store
//   mem_addr_o            word-aligned address
//   mem_wdata_o, mem_be_o store data and byte enables
//   stall_o               upstream must hold its inputs
//   wb_valid_o, wb_we_o   one-cycle retire pulse, register write enable
//   wb_rd_o, wb_data_o    destination register and write-back value
//   fault_o, fault_cause_o fault pulse with retire; 01 misaligned,
//                          10 unsupported width, 11 timeout
// -----------------------------------------------------------------------------
module mem_stage #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk_i,
    input  logic        rsn_i,
    input  logic        valid_i,
    input  logic [63:0] pc_i,
    input  logic [31:0] instr_i,
    input  logic [63:0] alu_result_i,
    input  logic [63:0] store_data_i,
    input  logic        mem_ready_i,
    input  logic [31:0] mem_rdata_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [63:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_be_o,
    output logic        stall_o,
    output logic        wb_valid_o,
    output logic        wb_we_o,
    output logic [4:0]  wb_rd_o,
    output logic [63:0] wb_data_o,
    output logic        fault_o,
    output logic [1:0]  fault_cause_o
);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } state_e;

    localparam logic [6:0] OP_OP    = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [2:0] F3_BYTE = 3'b000;
    localparam logic [2:0] F3_WORD = 3'b010;

    localparam logic [1:0] CAUSE_NONE     = 2'b00;
    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_WIDTH    = 2'b10;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

    localparam int unsigned    CNT_W    = $clog2(TIMEOUT + 1);
    // Counter value during the last cycle the request may stay up unanswered.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    // Instruction fields.
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [4:0] rd;
    assign opcode = instr_i[6:0];
    assign rd     = instr_i[11:7];
    assign funct3 = instr_i[14:12];

    // Upper instruction bits and the upper store half carry nothing this stage needs.
    logic unused_bits;
    assign unused_bits = ^{instr_i[31:15], store_data_i[63:32]};

    state_e            state_q,     state_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic              mem_we_q,    mem_we_d;
    logic [63:0]       mem_addr_q,  mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [3:0]        mem_be_q,    mem_be_d;
    logic [1:0]        off_q,       off_d;     // byte offset of the access
    logic              byte_q,      byte_d;    // 1 = LB/SB, 0 = LW/SW
    logic              wb_valid_q,  wb_valid_d;
    logic              wb_we_q,     wb_we_d;
    logic [4:0]        wb_rd_q,     wb_rd_d;
    logic [63:0]       wb_data_q,   wb_data_d;
    logic              fault_q,     fault_d;
    logic [1:0]        cause_q,     cause_d;

    logic is_mem_op, width_ok, misaligned, is_store;
    assign is_mem_op  = (opcode == OP_LOAD) || (opcode == OP_STORE);
    assign is_store   = (opcode == OP_STORE);
    assign width_ok   = (funct3 == F3_BYTE) || (funct3 == F3_WORD);
    assign misaligned = (funct3 == F3_WORD) && (alu_result_i[1:0] != 2'b00);

    // Load result: the addressed byte or the whole word, sign-extended.
    logic [7:0]  rdata_byte;
    logic [63:0] load_data;
    assign rdata_byte = mem_rdata_i[{off_q, 3'b000} +: 8];
    assign load_data  = byte_q ? {{56{rdata_byte[7]}}, rdata_byte}
                               : {{32{mem_rdata_i[31]}}, mem_rdata_i};

    always_comb begin
        // NOTE: every _d gets a default before any branch so no path leaves a
        // combinational output unassigned, which would infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        off_d       = off_q;
        byte_d      = byte_q;
        wb_rd_d     = wb_rd_q;
        wb_data_d   = wb_data_q;
        wb_valid_d  = 1'b0;
        wb_we_d     = 1'b0;
        fault_d     = 1'b0;
        cause_d     = CAUSE_NONE;

        if (state_q == S_IDLE) begin
            if (valid_i) begin
                wb_rd_d = rd;
                if (is_mem_op) begin
                    if (!width_ok) begin
                        wb_valid_d = 1'b1;
                        fault_d    = 1'b1;
                        cause_d    = CAUSE_WIDTH;
                    end else if (misaligned) begin
                        wb_valid_d = 1'b1;
                        fault_d    = 1'b1;
                        cause_d    = CAUSE_MISALIGN;
                    end else begin
                        state_d    = S_ACCESS;
                        cnt_d      = '0;
                        mem_we_d   = is_store;
                        mem_addr_d = {alu_result_i[63:2], 2'b00};
                        off_d      = alu_result_i[1:0];
                        byte_d     = (funct3 == F3_BYTE);
                        // Reads always fetch the full word; only byte stores narrow the enables.
                        if (is_store && (funct3 == F3_BYTE)) begin
                            mem_be_d    = 4'b0001 << alu_result_i[1:0];
                            mem_wdata_d = {4{store_data_i[7:0]}};
                        end else begin
                            mem_be_d    = 4'b1111;
                            mem_wdata_d = store_data_i[31:0];
                        end
                    end
                end else if ((opcode == OP_OP) || (opcode == OP_IMM)) begin
                    wb_valid_d = 1'b1;
                    wb_we_d    = (rd != 5'd0);
                    wb_data_d  = alu_result_i;
                end else if (opcode == OP_JAL) begin
                    wb_valid_d = 1'b1;
                    wb_we_d    = (rd != 5'd0);
                    wb_data_d  = pc_i + 64'd4;
                end else begin
                    // Branches and unlisted opcodes retire without a write.
                    wb_valid_d = 1'b1;
                end
            end
        end else begin
            // A response in the final counted cycle still completes normally.
            if (mem_ready_i) begin
                state_d    = S_IDLE;
                wb_valid_d = 1'b1;
                wb_we_d    = !mem_we_q && (wb_rd_q != 5'd0);
                wb_data_d  = load_data;
            end else if (cnt_q == CNT_LAST) begin
                state_d    = S_IDLE;
                wb_valid_d = 1'b1;
                fault_d    = 1'b1;
                cause_d    = CAUSE_TIMEOUT;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop.
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            off_q       <= '0;
            byte_q      <= 1'b0;
            wb_valid_q  <= 1'b0;
            wb_we_q     <= 1'b0;
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
            fault_q     <= 1'b0;
            cause_q     <= CAUSE_NONE;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            off_q       <= off_d;
            byte_q      <= byte_d;
            wb_valid_q  <= wb_valid_d;
            wb_we_q     <= wb_we_d;
            wb_rd_q     <= wb_rd_d;
            wb_data_q   <= wb_data_d;
            fault_q     <= fault_d;
            cause_q     <= cause_d;
        end
    end

    // Request and stall follow the state register directly, so reset drops them at once.
    assign mem_req_o     = (state_q == S_ACCESS);
    assign stall_o       = (state_q == S_ACCESS);
    assign mem_we_o      = mem_we_q;
    assign mem_addr_o    = mem_addr_q;
    assign mem_wdata_o   = mem_wdata_q;
    assign mem_be_o      = mem_be_q;
    assign wb_valid_o    = wb_valid_q;
    assign wb_we_o       = wb_we_q;
    assign wb_rd_o       = wb_rd_q;
    assign wb_data_o     = wb_data_q;
    assign fault_o       = fault_q;
    assign fault_cause_o = cause_q;

endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage -- self-checking bench for mem_stage.
// Table of single-cycle instructions with hand-derived results, hand-written
// multi-cycle memory sequences, then random instructions checked against a
// behavioural model of the retire rules.
// -----------------------------------------------------------------------------
module tb_mem_stage;

    localparam int unsigned TIMEOUT = 64;

    localparam logic [6:0] OP_OP    = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    logic        clk_i        = 1'b0;
    logic        rsn_i        = 1'b1;
    logic        valid_i      = 1'b0;
    logic [63:0] pc_i         = '0;
    logic [31:0] instr_i      = '0;
    logic [63:0] alu_result_i = '0;
    logic [63:0] store_data_i = '0;
    logic        mem_ready_i  = 1'b0;
    logic [31:0] mem_rdata_i  = '0;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [63:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        stall_o;
    logic        wb_valid_o;
    logic        wb_we_o;
    logic [4:0]  wb_rd_o;
    logic [63:0] wb_data_o;
    logic        fault_o;
    logic [1:0]  fault_cause_o;

    mem_stage #(.TIMEOUT(TIMEOUT)) dut (
        .clk_i        (clk_i),
        .rsn_i        (rsn_i),
        .valid_i      (valid_i),
        .pc_i         (pc_i),
        .instr_i      (instr_i),
        .alu_result_i (alu_result_i),
        .store_data_i (store_data_i),
        .mem_ready_i  (mem_ready_i),
        .mem_rdata_i  (mem_rdata_i),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_be_o     (mem_be_o),
        .stall_o      (stall_o),
        .wb_valid_o   (wb_valid_o),
        .wb_we_o      (wb_we_o),
        .wb_rd_o      (wb_rd_o),
        .wb_data_o    (wb_data_o),
        .fault_o      (fault_o),
        .fault_cause_o(fault_cause_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Expected behaviour of one instruction.
    typedef struct {
        bit          access;   // a memory request is expected
        bit          mem_we;
        logic [63:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        bit          wb_we;
        logic [4:0]  rd;
        bit          chk;      // rd and data are meaningful
        logic [63:0] data;
        bit          fault;
        logic [1:0]  cause;
    } exp_t;

    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
        logic [63:0] alu;
        logic [63:0] sd;
        bit          we;
        logic [4:0]  rd;
        bit          chk;
        logic [63:0] data;
        bit          fault;
        logic [1:0]  cause;
    } vec_t;

    function automatic logic [31:0] enc(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd);
        return {17'h0, f3, rd, op};
    endfunction

    // Behavioural model: retire result from the architectural rules.
    function automatic exp_t model(input logic [31:0] instr, input logic [63:0] pc,
                                   input logic [63:0] alu, input logic [63:0] sd,
                                   input logic [31:0] rdata, input bit timed_out);
        exp_t            e;
        logic [6:0]      op;
        int unsigned     f3;
        int unsigned     off;
        longint unsigned v;
        e   = '{default: 0};
        op  = instr[6:0];
        f3  = 32'(instr[14:12]);
        off = 32'(alu % 64'd4);
        e.rd = instr[11:7];
        if (op == OP_OP || op == OP_IMM) begin
            e.wb_we = (e.rd != 5'd0); e.chk = 1; e.data = alu;
        end else if (op == OP_JAL) begin
            e.wb_we = (e.rd != 5'd0); e.chk = 1; e.data = pc + 64'd4;
        end else if (op == OP_LOAD || op == OP_STORE) begin
            if (f3 != 0 && f3 != 2) begin
                e.fault = 1; e.cause = 2'd2;
            end else if (f3 == 2 && off != 0) begin
                e.fault = 1; e.cause = 2'd1;
            end else begin
                e.access = 1;
                e.mem_we = (op == OP_STORE);
                e.addr   = alu - 64'(off);
                if (e.mem_we && f3 == 0) begin
                    e.be    = 4'(32'd1 << off);
                    e.wdata = 32'(sd[7:0]) * 32'h0101_0101;
                end else begin
                    e.be    = 4'hF;
                    e.wdata = e.mem_we ? sd[31:0] : 32'h0;
                end
                if (timed_out) begin
                    e.fault = 1; e.cause = 2'd3;
                end else if (!e.mem_we) begin
                    e.wb_we = (e.rd != 5'd0);
                    e.chk   = 1;
                    if (f3 == 0) begin
                        v = (64'(rdata) >> (8 * off)) & 64'd255;
                        e.data = (v >= 64'd128) ? v - 64'd256 : v;
                    end else begin
                        v = 64'(rdata);
                        e.data = (v >= 64'h8000_0000) ? v - 64'h1_0000_0000 : v;
                    end
                end
            end
        end
        return e;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic [31:0] instr, input logic [63:0] pc,
                         input logic [63:0] alu, input logic [63:0] sd);
        valid_i      = 1'b1;
        instr_i      = instr;
        pc_i         = pc;
        alu_result_i = alu;
        store_data_i = sd;
    endtask

    task automatic check_idle(input string name);
        check({name, " idle"}, 128'({wb_valid_o, wb_we_o, fault_o, fault_cause_o, mem_req_o, stall_o}), 128'(0));
    endtask

    task automatic check_retire(input exp_t e, input string name);
        check({name, " wb_valid"}, 128'(wb_valid_o), 128'(1));
        check({name, " wb_we"}, 128'(wb_we_o), 128'(e.wb_we));
        check({name, " fault"}, 128'({fault_o, fault_cause_o}), 128'({e.fault, e.cause}));
        check({name, " req/stall"}, 128'({mem_req_o, stall_o}), 128'(0));
        if (e.chk) begin
            check({name, " wb_rd"}, 128'(wb_rd_o), 128'(e.rd));
            check({name, " wb_data"}, 128'(wb_data_o), 128'(e.data));
        end
    endtask

    // Instruction that must retire the cycle after acceptance without a request.
    task automatic run_single(input logic [31:0] instr, input logic [63:0] pc, input logic [63:0] alu,
                              input logic [63:0] sd, input exp_t e, input string name);
        drive(instr, pc, alu, sd);
        step();
        valid_i = 1'b0;
        instr_i = $urandom;
        check_retire(e, name);
        step();
        check_idle(name);
    endtask

    // Memory instruction; latency = ACCESS cycle in which mem_ready_i rises, 0 = never.
    task automatic run_mem(input logic [31:0] instr, input logic [63:0] pc, input logic [63:0] alu,
                           input logic [63:0] sd, input int latency, input logic [31:0] rdata,
                           input exp_t e, input string name);
        int          req_cycles;
        logic [31:0] act_wdata;
        req_cycles = 0;
        drive(instr, pc, alu, sd);
        step();
        for (int k = 1; k <= int'(TIMEOUT) + 4; k++) begin
            if (!mem_req_o) break;
            req_cycles++;
            act_wdata = e.mem_we ? mem_wdata_o : 32'h0;
            check({name, " request"}, 128'({stall_o, mem_we_o, mem_addr_o, act_wdata, mem_be_o}),
                  128'({1'b1, e.mem_we, e.addr, e.wdata, e.be}));
            mem_ready_i = (k == latency);
            mem_rdata_i = (k == latency) ? rdata : $urandom;
            step();
        end
        mem_ready_i = 1'b0;
        valid_i     = 1'b0;
        check({name, " req_cycles"}, 128'(req_cycles), 128'((latency == 0) ? int'(TIMEOUT) : latency));
        check_retire(e, name);
        step();
        check_idle(name);
    endtask

    initial begin
        #800_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t            vecs[$];
        exp_t            e;
        logic [31:0]     instr, tmp, rdata;
        logic [63:0]     pc, alu, sd;
        logic [6:0]      op;
        logic [2:0]      f3;
        logic [4:0]      rdn;
        int unsigned     sel;
        int              lat;

        // ---------------- reset, asserted before any clock edge
        #2 rsn_i = 1'b0;
        #1;
        check("reset mem outputs", 128'({mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o, stall_o}), 128'(0));
        check("reset wb outputs", 128'({wb_valid_o, wb_we_o, wb_rd_o, wb_data_o, fault_o, fault_cause_o}), 128'(0));
        step();
        step();
        rsn_i = 1'b1;

        // ---------------- mem_ready_i while idle has no effect
        mem_ready_i = 1'b1;
        mem_rdata_i = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            step();
            check_idle($sformatf("ready_in_idle%0d", i));
        end
        mem_ready_i = 1'b0;

        // ---------------- table of single-cycle instructions
        vecs.push_back('{enc(OP_OP, 3'd0, 5'd5), 64'h0, 64'h10, 64'h0, 1'b1, 5'd5, 1'b1, 64'h10, 1'b0, 2'b00});
        vecs.push_back('{enc(OP_IMM, 3'd0, 5'd0), 64'h0, 64'h1234, 64'h0, 1'b0, 5'd0, 1'b1, 64'h1234, 1'b0, 2'b00});
        vecs.push_back('{enc(OP_JAL, 3'd0, 5'd1), 64'h1000, 64'h0, 64'h0, 1'b1, 5'd1, 1'b1, 64'h1004, 1'b0, 2'b00});
        vecs.push_back('{enc(OP_JAL, 3'd0, 5'd7), 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 64'h0, 1'b1, 5'd7, 1'b1, 64'h0, 1'b0, 2'b00});
        vecs.push_back('{enc(OP_BR, 3'd0, 5'd3), 64'h40, 64'h1, 64'h0, 1'b0, 5'd3, 1'b0, 64'h0, 1'b0, 2'b00});
        vecs.push_back('{enc(OP_LUI, 3'd0, 5'd4), 64'h0, 64'h5000, 64'h0, 1'b0, 5'd4, 1'b0, 64'h0, 1'b0, 2'b00});
        vecs.push_back('{enc(OP_LOAD, 3'd2, 5'd6), 64'h0, 64'h2002, 64'h0, 1'b0, 5'd6, 1'b0, 64'h0, 1'b1, 2'b01});
        vecs.push_back('{enc(OP_STORE, 3'd2, 5'd0), 64'h0, 64'h2001, 64'h77, 1'b0, 5'd0, 1'b0, 64'h0, 1'b1, 2'b01});
        vecs.push_back('{enc(OP_LOAD, 3'd1, 5'd9), 64'h0, 64'h2000, 64'h0, 1'b0, 5'd9, 1'b0, 64'h0, 1'b1, 2'b10});
        vecs.push_back('{enc(OP_STORE, 3'd3, 5'd9), 64'h0, 64'h2000, 64'h0, 1'b0, 5'd9, 1'b0, 64'h0, 1'b1, 2'b10});
        vecs.push_back('{enc(OP_LOAD, 3'd4, 5'd9), 64'h0, 64'h2003, 64'h0, 1'b0, 5'd9, 1'b0, 64'h0, 1'b1, 2'b10});
        foreach (vecs[i]) begin
            e       = '{default: 0};
            e.wb_we = vecs[i].we;
            e.rd    = vecs[i].rd;
            e.chk   = vecs[i].chk;
            e.data  = vecs[i].data;
            e.fault = vecs[i].fault;
            e.cause = vecs[i].cause;
            run_single(vecs[i].instr, vecs[i].pc, vecs[i].alu, vecs[i].sd, e, $sformatf("vec%0d", i));
        end

        // ---------------- LB, 3-cycle latency, negative byte
        e = '{default: 0};
        e.access = 1; e.addr = 64'h1000; e.be = 4'hF;
        e.wb_we = 1; e.rd = 5'd3; e.chk = 1; e.data = 64'hFFFF_FFFF_FFFF_FF80;
        run_mem(enc(OP_LOAD, 3'd0, 5'd3), 64'h0, 64'h1003, 64'h0, 3, 32'h80FF_FFFF, e, "lb_lat3");

        // ---------------- SB at minimum latency
        e = '{default: 0};
        e.access = 1; e.mem_we = 1; e.addr = 64'h2000; e.be = 4'b0100; e.wdata = 32'hABAB_ABAB;
        run_mem(enc(OP_STORE, 3'd0, 5'd0), 64'h0, 64'h2002, 64'hAB, 1, 32'h0, e, "sb_lat1");

        // ---------------- LW with no response: timeout
        e = '{default: 0};
        e.access = 1; e.addr = 64'h3000; e.be = 4'hF; e.fault = 1; e.cause = 2'b11;
        run_mem(enc(OP_LOAD, 3'd2, 5'd9), 64'h0, 64'h3000, 64'h0, 0, 32'h0, e, "lw_timeout");

        // ---------------- LW answered in the last allowed cycle
        e = '{default: 0};
        e.access = 1; e.addr = 64'h3004; e.be = 4'hF;
        e.wb_we = 1; e.rd = 5'd12; e.chk = 1; e.data = 64'h7FFF_0001;
        run_mem(enc(OP_LOAD, 3'd2, 5'd12), 64'h0, 64'h3004, 64'h0, int'(TIMEOUT), 32'h7FFF_0001, e, "lw_last_cycle");

        // ---------------- back-to-back: ADD retires while LB is accepted
        drive(enc(OP_OP, 3'd0, 5'd2), 64'h0, 64'h55, 64'h0);
        step();
        drive(enc(OP_LOAD, 3'd0, 5'd8), 64'h0, 64'h5001, 64'h0);
        check("b2b add wb", 128'({wb_valid_o, wb_we_o, wb_rd_o, wb_data_o, stall_o}), 128'({1'b1, 1'b1, 5'd2, 64'h55, 1'b0}));
        step();
        check("b2b lb accepted", 128'({stall_o, mem_req_o, mem_addr_o, wb_valid_o}), 128'({1'b1, 1'b1, 64'h5000, 1'b0}));
        mem_ready_i = 1'b1;
        mem_rdata_i = 32'h0000_7F00;
        step();
        mem_ready_i = 1'b0;
        valid_i     = 1'b0;
        e = '{default: 0};
        e.wb_we = 1; e.rd = 5'd8; e.chk = 1; e.data = 64'h7F;
        check_retire(e, "b2b lb");

        // ---------------- reset in the middle of an access
        drive(enc(OP_LOAD, 3'd2, 5'd10), 64'h0, 64'h4000, 64'h0);
        step();
        step();
        check("pre-reset access", 128'({mem_req_o, stall_o}), 128'({1'b1, 1'b1}));
        #2 rsn_i = 1'b0;
        #1;
        valid_i = 1'b0;
        check("mid-reset mem outputs", 128'({mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o, stall_o}), 128'(0));
        check("mid-reset wb outputs", 128'({wb_valid_o, wb_we_o, wb_rd_o, wb_data_o, fault_o, fault_cause_o}), 128'(0));
        step();
        rsn_i       = 1'b1;
        mem_ready_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check_idle($sformatf("post_reset%0d", i));
        end
        mem_ready_i = 1'b0;

        // ---------------- random instructions against the model
        for (int n = 0; n < 60; n++) begin
            sel = $urandom_range(0, 7);
            case (sel)
                0:       op = OP_OP;
                1:       op = OP_IMM;
                2:       op = OP_JAL;
                3:       op = OP_BR;
                4:       op = 7'($urandom);
                5, 6:    op = OP_LOAD;
                default: op = OP_STORE;
            endcase
            f3    = ($urandom_range(0, 3) == 0) ? 3'($urandom) : ($urandom_range(0, 1) == 1 ? 3'b010 : 3'b000);
            rdn   = 5'($urandom);
            tmp   = $urandom;
            instr = {tmp[31:15], f3, rdn, op};
            pc    = {$urandom, $urandom};
            alu   = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) alu[1:0] = 2'b00;
            sd    = {$urandom, $urandom};
            rdata = $urandom;
            lat   = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 5));
            e     = model(instr, pc, alu, sd, rdata, lat == 0);
            if (e.access)
                run_mem(instr, pc, alu, sd, lat, rdata, e, $sformatf("rnd%0d", n));
            else
                run_single(instr, pc, alu, sd, e, $sformatf("rnd%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
